// File: rtl/miner_pkg.sv
// Shared constants and types for the hasher dispatch controller.
package miner_pkg;

  localparam logic [31:0] TARGET     = 32'ha41f32e7;
  localparam logic [3:0]  NONCE_SPAN = 4'd8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    RUN   = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/golden_fifo.sv
// Small synchronous FIFO that queues golden nonces for the serial transmitter.
module golden_fifo #(
  parameter int DEPTH = 4
) (
  input  logic        hash_clk,
  input  logic        reset,
  input  logic        push,
  input  logic [31:0] din,
  input  logic        pop,
  output logic [31:0] dout,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          wr_en, rd_en;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign dout  = mem_q[rd_ptr_q];

  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  always_ff @(posedge hash_clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge hash_clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end
  end

endmodule

// File: rtl/hash_dispatch_ctrl.sv
// Sequencer for the folded SHA-256 hasher: round counter, nonce stream,
// result blanking, target screening and golden-nonce transmit handshake.
//   state | meaning
//   IDLE  | hasher held, nonce parked at range base
//   FLUSH | hasher running, stale results suppressed
//   RUN   | hasher running, results screened against TARGET
module hash_dispatch_ctrl
  import miner_pkg::*;
#(
  parameter int          LOOP_LOG2     = 1,
  parameter logic [31:0] GOLDEN_OFFSET = 32'd33,
  parameter logic [7:0]  BLANK_CYCLES  = 8'd66,
  parameter int          FIFO_DEPTH    = 4
) (
  input  logic                 hash_clk,
  input  logic                 reset,
  input  logic                 halt,
  input  logic [3:0]           dip,
  input  logic                 work_new,
  input  logic [31:0]          hash_hi,
  input  logic                 tx_busy,
  output logic [LOOP_LOG2-1:0] cnt,
  output logic                 feedback,
  output logic [31:0]          nonce,
  output logic                 tx_send,
  output logic [31:0]          tx_word,
  output logic                 range_wrap,
  output logic                 fifo_overflow
);

  ctrl_state_t          state_q;
  logic [LOOP_LOG2-1:0] cnt_q, cnt_d;
  logic                 feedback_q, fb_dly_q;
  logic [31:0]          nonce_q, nonce_base;
  logic [7:0]           blank_q;
  logic                 range_wrap_q;
  logic                 match_q, push_q;
  logic                 tx_send_q, overflow_q;
  logic [31:0]          tx_word_q;
  logic                 check, pop;
  logic                 fifo_full, fifo_empty;
  logic [31:0]          fifo_dout;

  assign nonce_base = {dip, 28'h0};
  assign cnt_d      = cnt_q + LOOP_LOG2'(1);

  always_ff @(posedge hash_clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      feedback_q   <= 1'b0;
      nonce_q      <= nonce_base;
      blank_q      <= '0;
      range_wrap_q <= 1'b0;
    end else begin
      range_wrap_q <= 1'b0;
      if (halt) begin
        state_q    <= IDLE;
        cnt_q      <= '0;
        feedback_q <= 1'b0;
        nonce_q    <= nonce_base;
      end else begin
        case (state_q)
          IDLE: begin
            cnt_q      <= '0;
            feedback_q <= 1'b0;
            nonce_q    <= nonce_base;
            if (work_new) begin
              state_q <= FLUSH;
              blank_q <= BLANK_CYCLES;
            end
          end
          FLUSH, RUN: begin
            if (work_new) begin
              state_q    <= FLUSH;
              blank_q    <= BLANK_CYCLES;
              cnt_q      <= '0;
              feedback_q <= 1'b0;
              nonce_q    <= nonce_base;
            end else begin
              cnt_q      <= cnt_d;
              feedback_q <= (cnt_d != '0);
              if (state_q == FLUSH) begin
                blank_q <= blank_q - 8'd1;
                if (blank_q == 8'd1) state_q <= RUN;
              end
              // Wrap overrides the FLUSH countdown above when both land together.
              if (cnt_d == '0) begin
                if (nonce_q[31:28] == dip + NONCE_SPAN) begin
                  nonce_q      <= nonce_base;
                  range_wrap_q <= 1'b1;
                  state_q      <= FLUSH;
                  blank_q      <= BLANK_CYCLES;
                end else begin
                  nonce_q <= nonce_q + 32'd1;
                end
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign check = (state_q == RUN) && !fb_dly_q;
  assign pop   = !fifo_empty && !tx_busy && !tx_send_q;

  always_ff @(posedge hash_clk) begin
    if (reset) begin
      fb_dly_q   <= 1'b0;
      match_q    <= 1'b0;
      push_q     <= 1'b0;
      tx_send_q  <= 1'b0;
      tx_word_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      fb_dly_q  <= feedback_q;
      match_q   <= check && (hash_hi == TARGET);
      push_q    <= match_q;
      tx_send_q <= pop;
      if (pop) tx_word_q <= fifo_dout;
      if (push_q && fifo_full && !pop) overflow_q <= 1'b1;
    end
  end

  golden_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .hash_clk (hash_clk),
    .reset    (reset),
    .push     (push_q),
    .din      (nonce_q - GOLDEN_OFFSET),
    .pop      (pop),
    .dout     (fifo_dout),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign cnt           = cnt_q;
  assign feedback      = feedback_q;
  assign nonce         = nonce_q;
  assign tx_send       = tx_send_q;
  assign tx_word       = tx_word_q;
  assign range_wrap    = range_wrap_q;
  assign fifo_overflow = overflow_q;

endmodule

// File: tb/tb_hash_dispatch_ctrl.sv
// Directed bench for hash_dispatch_ctrl with default parameters (LOOP=2, 66 blank cycles, depth 4).
module tb_hash_dispatch_ctrl;
  import miner_pkg::*;

  localparam int LOOP_LOG2 = 1;

  logic                 hash_clk = 1'b0;
  logic                 reset    = 1'b1;
  logic                 halt     = 1'b0;
  logic [3:0]           dip      = 4'h3;
  logic                 work_new = 1'b0;
  logic [31:0]          hash_hi  = 32'h0;
  logic                 tx_busy  = 1'b0;
  logic [LOOP_LOG2-1:0] cnt;
  logic                 feedback;
  logic [31:0]          nonce;
  logic                 tx_send;
  logic [31:0]          tx_word;
  logic                 range_wrap;
  logic                 fifo_overflow;

  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  logic [31:0] sw_word[$];
  int          sw_cyc[$];

  hash_dispatch_ctrl dut (
    .hash_clk      (hash_clk),
    .reset         (reset),
    .halt          (halt),
    .dip           (dip),
    .work_new      (work_new),
    .hash_hi       (hash_hi),
    .tx_busy       (tx_busy),
    .cnt           (cnt),
    .feedback      (feedback),
    .nonce         (nonce),
    .tx_send       (tx_send),
    .tx_word       (tx_word),
    .range_wrap    (range_wrap),
    .fifo_overflow (fifo_overflow)
  );

  always #5 hash_clk = ~hash_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge hash_clk);
    #1;
    cyc++;
    if (tx_send === 1'b1) begin
      sw_word.push_back(tx_word);
      sw_cyc.push_back(cyc);
    end
  endtask

  task automatic work_pulse();
    work_new = 1'b1;
    step();
    work_new = 1'b0;
  endtask

  initial begin
    // Reset values
    step();
    step();
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    chk("rst_nonce", nonce, 32'h3000_0000);
    chk("rst_cnt", 32'(cnt), 32'd0);
    chk("rst_fb", 32'(feedback), 32'd0);
    chk("rst_tx_send", 32'(tx_send), 32'd0);
    chk("rst_tx_word", tx_word, 32'd0);
    chk("rst_wrap", 32'(range_wrap), 32'd0);
    chk("rst_ovf", 32'(fifo_overflow), 32'd0);
    reset = 1'b0;

    // Idle without work: hasher parked at base
    for (int i = 0; i < 100; i++) begin
      step();
      chk("idle_nonce", nonce, 32'h3000_0000);
      chk("idle_fb", 32'(feedback), 32'd0);
      chk("idle_cnt", 32'(cnt), 32'd0);
      chk("idle_tx_send", 32'(tx_send), 32'd0);
    end
    dip = 4'hA;
    step();
    chk("idle_track_dip", nonce, 32'hA000_0000);
    dip = 4'h3;
    step();
    chk("idle_track_dip_back", nonce, 32'h3000_0000);

    // Work: counter/nonce stream, blanking window, then one golden nonce at 3000_0100
    sw_word.delete();
    sw_cyc.delete();
    work_pulse();
    for (int k = 0; k <= 520; k++) begin
      chk("run_cnt", 32'(cnt), 32'(k % 2));
      chk("run_fb", 32'(feedback), 32'(k % 2));
      chk("run_nonce", nonce, 32'h3000_0000 + 32'(k / 2));
      chk("run_wrap", 32'(range_wrap), 32'd0);
      if (k == 513) chk("no_send_from_blank", 32'(sw_word.size()), 32'd0);
      hash_hi = (k <= 66 || k == 511) ? TARGET : 32'h0;
      step();
    end
    chk("golden_send_count", 32'(sw_word.size()), 32'd1);
    if (sw_word.size() > 0) chk("golden_word", sw_word[0], 32'h3000_00DF);

    // Range wrap with dip=F: 7FFF_FFFF -> F000_0000
    dip = 4'hF;
    work_pulse();
    for (int k = 0; k < 68; k++) step();
    chk("wrap_pre_state", 32'(dut.state_q), 32'(RUN));
    chk("wrap_pre_cnt", 32'(cnt), 32'd0);
    force dut.nonce_q = 32'h7FFF_FFFF;
    #1;
    release dut.nonce_q;
    chk("wrap_forced", nonce, 32'h7FFF_FFFF);
    step();
    chk("wrap_hold_nonce", nonce, 32'h7FFF_FFFF);
    chk("wrap_hold_pulse", 32'(range_wrap), 32'd0);
    chk("wrap_hold_cnt", 32'(cnt), 32'd1);
    step();
    chk("wrap_nonce", nonce, 32'hF000_0000);
    chk("wrap_pulse", 32'(range_wrap), 32'd1);
    chk("wrap_state", 32'(dut.state_q), 32'(FLUSH));
    chk("wrap_cnt", 32'(cnt), 32'd0);
    step();
    chk("wrap_pulse_end", 32'(range_wrap), 32'd0);
    chk("wrap_nonce_after", nonce, 32'hF000_0000);
    for (int k = 72; k < 136; k++) step();
    chk("wrap_blank_last", 32'(dut.state_q), 32'(FLUSH));
    step();
    chk("wrap_run_again", 32'(dut.state_q), 32'(RUN));
    chk("wrap_run_nonce", nonce, 32'hF000_0021);

    // Overflow under tx_busy, ordered drain, then halt with two queued entries
    dip = 4'h5;
    tx_busy = 1'b1;
    sw_word.delete();
    sw_cyc.delete();
    work_pulse();
    for (int k = 0; k <= 180; k++) begin
      if (k < 157) begin
        chk("q_cnt", 32'(cnt), 32'(k % 2));
        chk("q_nonce", nonce, 32'h5000_0000 + 32'(k / 2));
      end else begin
        chk("halt_nonce", nonce, 32'h5000_0000);
        chk("halt_cnt", 32'(cnt), 32'd0);
        chk("halt_fb", 32'(feedback), 32'd0);
        chk("halt_state", 32'(dut.state_q), 32'(IDLE));
      end
      if (k == 111) chk("ovf_before", 32'(fifo_overflow), 32'd0);
      if (k == 112) chk("ovf_set", 32'(fifo_overflow), 32'd1);
      if (k == 119) chk("busy_no_send", 32'(sw_word.size()), 32'd0);
      if (k == 150) begin
        chk("drain_count", 32'(sw_word.size()), 32'd4);
        if (sw_word.size() >= 4) begin
          for (int i = 0; i < 4; i++)
            chk("drain_word", sw_word[i], 32'h5000_0000 + 32'((103 + 2 * i) / 2) - 32'd33);
          for (int i = 1; i < 4; i++)
            chk("drain_gap", 32'(sw_cyc[i] - sw_cyc[i-1] >= 2), 32'd1);
        end
        sw_word.delete();
        sw_cyc.delete();
      end
      if (k == 180) chk("ovf_sticky", 32'(fifo_overflow), 32'd1);
      hash_hi = ((k >= 101 && k <= 109) || k == 151 || k == 153) ? TARGET : 32'h0;
      tx_busy = (k < 120) || (k >= 140 && k < 158);
      halt    = (k >= 156 && k <= 160);
      step();
    end
    chk("halt_send_count", 32'(sw_word.size()), 32'd2);
    if (sw_word.size() >= 2) begin
      chk("halt_word0", sw_word[0], 32'h5000_002B);
      chk("halt_word1", sw_word[1], 32'h5000_002C);
    end

    // halt beats work_new
    halt = 1'b1;
    work_new = 1'b1;
    step();
    work_new = 1'b0;
    halt = 1'b0;
    chk("prio_state", 32'(dut.state_q), 32'(IDLE));
    chk("prio_nonce", nonce, 32'h5000_0000);
    chk("prio_cnt", 32'(cnt), 32'd0);
    step();
    chk("prio_stay_idle", 32'(dut.state_q), 32'(IDLE));
    work_pulse();
    chk("resume_state", 32'(dut.state_q), 32'(FLUSH));
    step();
    chk("resume_cnt", 32'(cnt), 32'd1);
    chk("resume_fb", 32'(feedback), 32'd1);

    // reset beats halt and clears the sticky flag
    reset = 1'b1;
    halt = 1'b1;
    step();
    chk("rst2_ovf", 32'(fifo_overflow), 32'd0);
    chk("rst2_tx_word", tx_word, 32'd0);
    chk("rst2_state", 32'(dut.state_q), 32'(IDLE));
    chk("rst2_nonce", nonce, 32'h5000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
